// File: rtl/mem_write_checker_if.sv
// Monitored data-memory write bus: one write per cycle when memwrite is high.
interface mem_write_checker_if #(
  parameter int WIDTH = 32
);
  logic             memwrite;
  logic [WIDTH-1:0] dataadr;
  logic [WIDTH-1:0] writedata;

  modport master (output memwrite, dataadr, writedata);
  modport slave  (input  memwrite, dataadr, writedata);
endinterface

// File: rtl/mem_write_checker.sv
// Checks bus writes against a loaded (address, data) table; sticky pass/fail with failure details.
// Verdict registered on the deciding edge; the bus is observe-only, with no backpressure.
module mem_write_checker #(
  parameter int WIDTH    = 32,
  parameter int NUM_EXP  = 4,
  parameter int IDXW     = 2,
  parameter int TIMEOUT  = 1000,
  parameter int IGN_BASE = 80,
  parameter int IGN_SIZE = 4,
  parameter int ORDERED  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [IDXW:0]       exp_num,
  input  logic                exp_we,
  input  logic [IDXW-1:0]     exp_idx,
  input  logic [WIDTH-1:0]    exp_addr,
  input  logic [WIDTH-1:0]    exp_data,
  mem_write_checker_if.slave  bus,
  output logic                pass,
  output logic                fail,
  output logic                done,
  output logic [1:0]          fail_code,
  output logic [WIDTH-1:0]    fail_addr,
  output logic [WIDTH-1:0]    fail_data,
  output logic [IDXW:0]       match_count,
  output logic [31:0]         cycle_count
);

  localparam logic [IDXW:0]  NUM_MAX  = (IDXW+1)'(NUM_EXP);
  localparam logic [WIDTH:0] IGN_LO   = (WIDTH+1)'(IGN_BASE);
  localparam logic [WIDTH:0] IGN_HI   = (WIDTH+1)'(IGN_BASE + IGN_SIZE);
  localparam logic [31:0]    LAST_CYC = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]   tab_addr [NUM_EXP];
  logic [WIDTH-1:0]   tab_data [NUM_EXP];
  logic [NUM_EXP-1:0] tab_vld;
  logic [NUM_EXP-1:0] matched;
  logic [IDXW:0]      num_lat;

  logic            hit;
  logic [IDXW-1:0] hit_idx;
  logic            ign;
  logic            mism;
  logic            last_hit;
  logic            tout;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    // Scan downwards so the lowest qualifying index is the one left standing.
    for (int i = NUM_EXP - 1; i >= 0; i--) begin
      if (bus.memwrite && tab_vld[i] && ((IDXW+1)'(i) < num_lat) &&
          ((ORDERED != 0) ? (match_count == (IDXW+1)'(i)) : !matched[i]) &&
          (bus.dataadr == tab_addr[i]) && (bus.writedata == tab_data[i])) begin
        hit     = 1'b1;
        hit_idx = IDXW'(i);
      end
    end
    ign      = ({1'b0, bus.dataadr} >= IGN_LO) && ({1'b0, bus.dataadr} < IGN_HI);
    mism     = bus.memwrite && !hit && !ign;
    last_hit = hit && ((match_count + 1'b1) == num_lat);
    tout     = (cycle_count == LAST_CYC);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if ((num_lat == '0) || last_hit) state_nxt = S_PASS;
        else if (mism || tout)           state_nxt = S_FAIL;
      end
      default: begin
        if (start) state_nxt = S_RUN;
      end
    endcase
  end

  always_comb begin
    pass = (state == S_PASS);
    fail = (state == S_FAIL);
    done = pass | fail;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_EXP; i++) begin
        tab_addr[i] <= '0;
        tab_data[i] <= '0;
      end
      tab_vld     <= '0;
      matched     <= '0;
      num_lat     <= '0;
      match_count <= '0;
      cycle_count <= '0;
      fail_code   <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else if (state == S_RUN) begin
      if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      if (hit) begin
        matched[hit_idx] <= 1'b1;
        match_count      <= match_count + 1'b1;
      end
      // A mismatch on the timeout cycle is still reported as a mismatch.
      if (state_nxt == S_FAIL) begin
        if (mism) begin
          fail_code <= 2'd1;
          fail_addr <= bus.dataadr;
          fail_data <= bus.writedata;
        end else begin
          fail_code <= 2'd2;
        end
      end
    end else begin
      if ((state == S_IDLE) && exp_we) begin
        for (int i = 0; i < NUM_EXP; i++) begin
          if (exp_idx == IDXW'(i)) begin
            tab_addr[i] <= exp_addr;
            tab_data[i] <= exp_data;
            tab_vld[i]  <= 1'b1;
          end
        end
      end
      if (start) begin
        num_lat     <= (exp_num > NUM_MAX) ? NUM_MAX : exp_num;
        matched     <= '0;
        match_count <= '0;
        cycle_count <= '0;
        fail_code   <= '0;
        fail_addr   <= '0;
        fail_data   <= '0;
      end
    end
  end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
Synthesizable, parametrised successor to the single-shot "value X at address Y" pass/fail check in the MIPS processor bench. Monitors the processor data-memory write bus against a loaded table of up to NUM_EXP expected (address, data) writes. Supports in-order or any-order matching, an ignore window for scratch stores, and a cycle timeout. Reports sticky pass/fail status and failure details, so benches and FPGA self-test wrappers need no ad-hoc compare logic.

Parameters:
WIDTH, 32, address and data width of the monitored bus
NUM_EXP, 4, expected-table depth (≥1)
IDXW, 2, table index width; must satisfy 2**IDXW ≥ NUM_EXP
TIMEOUT, 1000, RUN cycles allowed before a timeout failure (≥1)
IGN_BASE, 80, base address of the ignore window
IGN_SIZE, 4, ignore-window size in bytes; 0 disables the window
ORDERED, 1, 1 = in-order matching; 0 = any order, each entry matched at most once

Ports:
clk  in  1  clock; all sampling on rising edge
reset  in  1  synchronous, active-high
start  in  1  arm checker; honoured in IDLE, PASS and FAIL
exp_num  in  IDXW+1  number of active table entries, latched on accepted start; values > NUM_EXP clamp to NUM_EXP
exp_we  in  1  table write strobe; honoured only in IDLE
exp_idx  in  IDXW  table write index; index ≥ NUM_EXP ignored
exp_addr  in  WIDTH  expected address to write
exp_data  in  WIDTH  expected data to write
memwrite  in  1  monitored bus write enable
dataadr  in  WIDTH  monitored bus address
writedata  in  WIDTH  monitored bus data
pass  out  1  sticky success
fail  out  1  sticky failure
done  out  1  pass | fail
fail_code  out  2  0 none, 1 mismatch, 2 timeout
fail_addr  out  WIDTH  dataadr of the offending write, else 0
fail_data  out  WIDTH  writedata of the offending write, else 0
match_count  out  IDXW+1  entries matched so far
cycle_count  out  32  cycles spent in RUN

Behaviour:
- States: IDLE, RUN, PASS, FAIL. Reset has priority over all inputs: → IDLE; every output 0; table, valid and matched bits cleared.
- IDLE: exp_we writes entry exp_idx, registered on the edge. start → RUN next cycle: latch exp_num, clear matched bits, match_count, cycle_count, fail_*.
- start with latched exp_num = 0: RUN lasts one cycle, then → PASS.
- RUN, every cycle: cycle_count += 1. If memwrite, evaluate the sampled write in this order:
  1. Match. ORDERED=1: compare against entry match_count. ORDERED=0: compare against any active, unmatched entry; lowest index wins. Compare is exact equality on address and data. On match: set matched bit; match_count += 1.
  2. Else ignore. If IGN_BASE ≤ dataadr < IGN_BASE+IGN_SIZE (unsigned), drop the write silently.
  3. Else fail. → FAIL, fail_code=1, capture fail_addr and fail_data.
- Completion: when match_count reaches latched exp_num → PASS on the same edge that registers the last match.
- Timeout: if cycle_count = TIMEOUT-1 and the cycle completes neither match nor mismatch → FAIL, fail_code=2, fail_addr=fail_data=0.
- Same cycle, final match and timeout: PASS wins.
- Same cycle, mismatch and timeout: fail_code=1.
- Write to a matched entry in an ORDERED=0 run is not a match; it goes to the ignore check, else mismatch.
- memwrite=0 cycles: only the counter advances.
- PASS/FAIL are sticky; monitored bus is ignored there. start re-arms → RUN with the table retained. exp_we ignored.
- start, exp_we in RUN: ignored.
- Outputs are registered; pass, fail and done assert the cycle after the deciding edge.
- cycle_count saturates at 2^32-1.

Test Plan:
- In-order pass. ORDERED=1, load {(84,7)}, exp_num=1, start. Bus writes (80,3), then (84,7). Required: pass=1, fail=0, match_count=1, fail_code=0.
- Mismatch. Same table; bus writes (88,7). Required: fail=1, fail_code=1, fail_addr=88, fail_data=7. A later (84,7) leaves pass=0.
- Any order. ORDERED=0, load {(84,7),(100,5),(104,9)}, exp_num=3. Bus writes (104,9), (84,7), (104,9) with ignore window disabled. Required: fail_code=1, fail_addr=104 on the repeat write. Without the repeat, (100,5) gives pass=1, match_count=3.
- Timeout. TIMEOUT=10, exp_num=1, no bus writes. Required: fail after 10 RUN cycles, fail_code=2, cycle_count=10. Variant with the final match on cycle 10: pass=1.
- Edge cases. exp_num=0 → pass. exp_num=7 with NUM_EXP=4 → needs 4 matches. exp_we during RUN leaves the table unchanged.
- Reset and re-arm. Assert reset mid-RUN after 1 of 2 matches: all outputs 0, table cleared. Reload, then start from PASS: runs again with the retained table.
